pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter TRAP_VECTOR, default 32'h0000_0100, address taken on trap or misaligned redirect.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 curr_pc  output  32  address of current fetch; drives the PC+4 adder.
REQ-006 pc_plus_4  input  32  combinational curr_pc+4 from the external adder.
REQ-007 fetch_valid  output  1  curr_pc is a valid fetch request.
REQ-008 fetch_ready  input  1  instruction memory accepts the fetch this cycle.
REQ-009 redirect_valid  input  1  branch/jump taken this cycle.
REQ-010 redirect_target  input  32  branch/jump destination.
REQ-011 trap_valid  input  1  exception raised by the core this cycle.
REQ-012 halt  input  1  level request to stop fetching.
REQ-013 misalign_err  output  1  one-cycle pulse: redirect target not word aligned.
REQ-014 bad_addr  output  32  last misaligned redirect_target captured.
REQ-015 fetch_cnt  output  32  count of accepted fetches.

Function
REQ-016 States SHALL be BOOT, FETCH, BUBBLE, HALTED.
REQ-017 BOOT: fetch_valid=0, curr_pc=RESET_VECTOR; SHALL go to FETCH next cycle unconditionally.
REQ-018 FETCH: fetch_valid=1; curr_pc SHALL hold while fetch_ready=0 and no redirect/trap (stall).
REQ-019 FETCH, event priority per cycle SHALL be trap_valid > redirect_valid > halt > accept.
REQ-020 trap_valid=1 (any state except BOOT): curr_pc<=TRAP_VECTOR, state<=BUBBLE, independent of fetch_ready.
REQ-021 redirect_valid=1 with redirect_target[1:0]==0: curr_pc<=redirect_target, state<=BUBBLE.
REQ-022 redirect_valid=1 with redirect_target[1:0]!=0: curr_pc<=TRAP_VECTOR, bad_addr<=redirect_target, misalign_err=1 next cycle only, state<=BUBBLE.
REQ-023 Accept (fetch_valid & fetch_ready, no trap/redirect): curr_pc<=pc_plus_4, fetch_cnt<=fetch_cnt+1.
REQ-024 Accept on the same cycle as trap/redirect SHALL still increment fetch_cnt; curr_pc takes the redirect value.
REQ-025 BUBBLE: fetch_valid=0 exactly one cycle; then FETCH, or HALTED if halt=1; a trap/redirect in BUBBLE SHALL overwrite curr_pc and stay BUBBLE one more cycle.
REQ-026 halt=1 in FETCH with no trap/redirect: state<=HALTED, curr_pc unchanged, pending fetch dropped.
REQ-027 HALTED: fetch_valid=0, curr_pc held; halt=0 SHALL return to FETCH next cycle; trap_valid SHALL load TRAP_VECTOR and go to BUBBLE; redirect_valid ignored.
REQ-028 fetch_cnt SHALL wrap 32'hFFFF_FFFF -> 0 without flag.
REQ-029 curr_pc arithmetic SHALL use pc_plus_4 only; wrap at 2^32 inherited from the adder (32'hFFFF_FFFC -> 0).
REQ-030 curr_pc SHALL be a register output; misalign_err registered; no combinational path inputs->fetch_valid.

Reset
REQ-031 rst_n=0 SHALL asynchronously force: state BOOT, curr_pc=RESET_VECTOR, fetch_valid=0, misalign_err=0, bad_addr=0, fetch_cnt=0.
REQ-032 Reset mid-stall or mid-BUBBLE SHALL discard all pending redirect/trap; release SHALL restart from BOOT.

Structure
REQ-033 State encoding (2-bit) and default vectors SHALL live in shared package riscv_pkg.
REQ-034 Single module; PC+4 adder SHALL remain external (pc_prefix_adder instanced at the level above); no sub-module inside.

Verification
REQ-035 Reset release, fetch_ready=1 -> curr_pc 0x0 (BOOT, valid=0), then 0x0,0x4,0x8 with valid=1, fetch_cnt 0,1,2,3.
REQ-036 fetch_ready=0 for 3 cycles at pc 0x8 -> curr_pc holds 0x8, fetch_cnt unchanged; ready=1 -> 0xC.
REQ-037 redirect_valid, target 0x40 at pc 0x10 -> one bubble cycle, then curr_pc 0x40 valid, 0x44 next.
REQ-038 redirect target 0x42 -> misalign_err pulse one cycle, bad_addr 0x42, curr_pc 0x100 after bubble.
REQ-039 trap_valid and redirect_valid (0x80) same cycle -> curr_pc 0x100, redirect lost.
REQ-040 halt=1 at pc 0x20 for 4 cycles -> fetch_valid=0, curr_pc 0x20; halt=0 -> fetch resumes at 0x20; preload fetch_cnt near 0xFFFF_FFFF -> wraps to 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: PC sequencer state encoding and default vectors.
// No logic; constants, types and one helper only.
// Not applicable (package).
package riscv_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_BUBBLE = 2'd2,
        ST_HALTED = 2'd3
    } pc_state_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

    function automatic logic word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: boot, fetch, redirect/trap bubble and halt control.
// Latency: redirect/trap lands in curr_pc next cycle, followed by one fetch_valid=0 bubble.
// Backpressure: fetch_ready=0 stalls curr_pc in FETCH; halt drops the pending fetch.
module pc_sequencer
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] curr_pc,
    input  logic [31:0] pc_plus_4,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        trap_valid,
    input  logic        halt,
    output logic        misalign_err,
    output logic [31:0] bad_addr,
    output logic [31:0] fetch_cnt
);

    pc_state_t   state_q, state_d;
    logic [31:0] pc_d;
    logic [31:0] bad_addr_d;
    logic        misalign_d;
    logic        flush;
    logic        accept;
    logic        cnt_inc;

    // Decoded from the state register only, so no input reaches fetch_valid.
    assign fetch_valid = (state_q == ST_FETCH);
    assign accept      = fetch_valid && fetch_ready;
    // Halt outranks accept, but an accept alongside a trap/redirect still counts.
    assign cnt_inc     = accept && (flush || !halt);

    always_comb begin
        state_d    = state_q;
        pc_d       = curr_pc;
        bad_addr_d = bad_addr;
        misalign_d = 1'b0;
        flush      = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
                pc_d    = RESET_VECTOR;
            end
            ST_FETCH, ST_BUBBLE: begin
                if (trap_valid) begin
                    flush   = 1'b1;
                    state_d = ST_BUBBLE;
                    pc_d    = TRAP_VECTOR;
                end else if (redirect_valid) begin
                    flush   = 1'b1;
                    state_d = ST_BUBBLE;
                    if (word_aligned(redirect_target)) begin
                        pc_d = redirect_target;
                    end else begin
                        pc_d       = TRAP_VECTOR;
                        bad_addr_d = redirect_target;
                        misalign_d = 1'b1;
                    end
                end else if (halt) begin
                    state_d = ST_HALTED;
                end else if (state_q == ST_BUBBLE) begin
                    state_d = ST_FETCH;
                end else if (accept) begin
                    pc_d = pc_plus_4;
                end
            end
            ST_HALTED: begin
                if (trap_valid) begin
                    state_d = ST_BUBBLE;
                    pc_d    = TRAP_VECTOR;
                end else if (!halt) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_BOOT;
                pc_d    = RESET_VECTOR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BOOT;
            curr_pc      <= RESET_VECTOR;
            bad_addr     <= 32'h0;
            misalign_err <= 1'b0;
            fetch_cnt    <= 32'h0;
        end else begin
            state_q      <= state_d;
            curr_pc      <= pc_d;
            bad_addr     <= bad_addr_d;
            misalign_err <= misalign_d;
            if (cnt_inc) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; models the external PC+4 adder.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] curr_pc;
    logic [31:0] pc_plus_4;
    logic        fetch_valid;
    logic        fetch_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_valid;
    logic        halt;
    logic        misalign_err;
    logic [31:0] bad_addr;
    logic [31:0] fetch_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign pc_plus_4 = curr_pc + 32'd4;

    pc_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .curr_pc         (curr_pc),
        .pc_plus_4       (pc_plus_4),
        .fetch_valid     (fetch_valid),
        .fetch_ready     (fetch_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .halt            (halt),
        .misalign_err    (misalign_err),
        .bad_addr        (bad_addr),
        .fetch_cnt       (fetch_cnt)
    );

    task automatic test_reset();
        rst_n = 1'b0; fetch_ready = 1'b1; redirect_valid = 1'b0;
        redirect_target = 32'h0; trap_valid = 1'b0; halt = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({fetch_valid, curr_pc, misalign_err, bad_addr, fetch_cnt} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_state: valid=%b pc=%h mis=%b bad=%h cnt=%h, expected 0/0/0/0/0",
                     fetch_valid, curr_pc, misalign_err, bad_addr, fetch_cnt);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if ({fetch_valid, curr_pc} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL boot_cycle: valid=%b pc=%h, expected 0/00000000", fetch_valid, curr_pc);
        end
        @(negedge clk);
        checks++;
        if ({fetch_valid, curr_pc, fetch_cnt} !== {1'b1, 32'h0, 32'd0}) begin
            errors++;
            $display("FAIL first_fetch: valid=%b pc=%h cnt=%0d, expected 1/00000000/0", fetch_valid, curr_pc, fetch_cnt);
        end
        @(negedge clk);
        checks++;
        if ({fetch_valid, curr_pc, fetch_cnt} !== {1'b1, 32'h4, 32'd1}) begin
            errors++;
            $display("FAIL seq_pc4: valid=%b pc=%h cnt=%0d, expected 1/00000004/1", fetch_valid, curr_pc, fetch_cnt);
        end
        @(negedge clk);
        checks++;
        if ({fetch_valid, curr_pc, fetch_cnt} !== {1'b1, 32'h8, 32'd2}) begin
            errors++;
            $display("FAIL seq_pc8: valid=%b pc=%h cnt=%0d, expected 1/00000008/2", fetch_valid, curr_pc, fetch_cnt);
        end
    endtask

    task automatic test_stall();
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({fetch_valid, curr_pc, fetch_cnt} !== {1'b1, 32'h8, 32'd2}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b pc=%h cnt=%0d, expected 1/00000008/2",
                         i, fetch_valid, curr_pc, fetch_cnt);
            end
        end
        fetch_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({curr_pc, fetch_cnt} !== {32'hC, 32'd3}) begin
            errors++;
            $display("FAIL stall_release: pc=%h cnt=%0d, expected 0000000c/3", curr_pc, fetch_cnt);
        end
        @(negedge clk);
        checks++;
        if ({curr_pc, fetch_cnt} !== {32'h10, 32'd4}) begin
            errors++;
            $display("FAIL seq_pc10: pc=%h cnt=%0d, expected 00000010/4", curr_pc, fetch_cnt);
        end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1; redirect_target = 32'h40;
        @(negedge clk);
        checks++;
        if ({fetch_valid, curr_pc, fetch_cnt} !== {1'b0, 32'h40, 32'd5}) begin
            errors++;
            $display("FAIL redirect_bubble: valid=%b pc=%h cnt=%0d, expected 0/00000040/5", fetch_valid, curr_pc, fetch_cnt);
        end
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({fetch_valid, curr_pc, fetch_cnt} !== {1'b1, 32'h40, 32'd5}) begin
            errors++;
            $display("FAIL redirect_fetch: valid=%b pc=%h cnt=%0d, expected 1/00000040/5", fetch_valid, curr_pc, fetch_cnt);
        end
        @(negedge clk);
        checks++;
        if ({fetch_valid, curr_pc, fetch_cnt} !== {1'b1, 32'h44, 32'd6}) begin
            errors++;
            $display("FAIL redirect_next: valid=%b pc=%h cnt=%0d, expected 1/00000044/6", fetch_valid, curr_pc, fetch_cnt);
        end
    endtask

    task automatic test_misalign();
        fetch_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h42;
        @(negedge clk);
        checks++;
        if ({fetch_valid, curr_pc, misalign_err, bad_addr} !== {1'b0, 32'h100, 1'b1, 32'h42}) begin
            errors++;
            $display("FAIL misalign_pulse: valid=%b pc=%h mis=%b bad=%h, expected 0/00000100/1/00000042",
                     fetch_valid, curr_pc, misalign_err, bad_addr);
        end
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({fetch_valid, curr_pc, misalign_err, bad_addr, fetch_cnt} !== {1'b1, 32'h100, 1'b0, 32'h42, 32'd6}) begin
            errors++;
            $display("FAIL misalign_after: valid=%b pc=%h mis=%b bad=%h cnt=%0d, expected 1/00000100/0/00000042/6",
                     fetch_valid, curr_pc, misalign_err, bad_addr, fetch_cnt);
        end
    endtask

    task automatic test_trap_redirect();
        fetch_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({curr_pc, fetch_cnt} !== {32'h104, 32'd7}) begin
            errors++;
            $display("FAIL trap_setup: pc=%h cnt=%0d, expected 00000104/7", curr_pc, fetch_cnt);
        end
        trap_valid = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h80;
        @(negedge clk);
        checks++;
        if ({fetch_valid, curr_pc, fetch_cnt, misalign_err} !== {1'b0, 32'h100, 32'd8, 1'b0}) begin
            errors++;
            $display("FAIL trap_wins: valid=%b pc=%h cnt=%0d mis=%b, expected 0/00000100/8/0",
                     fetch_valid, curr_pc, fetch_cnt, misalign_err);
        end
        trap_valid = 1'b0; redirect_valid = 1'b0; fetch_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({fetch_valid, curr_pc} !== {1'b1, 32'h100}) begin
            errors++;
            $display("FAIL trap_resume: valid=%b pc=%h, expected 1/00000100", fetch_valid, curr_pc);
        end
    endtask

    task automatic test_bubble_redirect();
        redirect_valid = 1'b1; redirect_target = 32'h40;
        @(negedge clk);
        redirect_target = 32'h60;
        @(negedge clk);
        checks++;
        if ({fetch_valid, curr_pc} !== {1'b0, 32'h60}) begin
            errors++;
            $display("FAIL bubble_redirect: valid=%b pc=%h, expected 0/00000060", fetch_valid, curr_pc);
        end
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({fetch_valid, curr_pc} !== {1'b1, 32'h60}) begin
            errors++;
            $display("FAIL bubble_exit: valid=%b pc=%h, expected 1/00000060", fetch_valid, curr_pc);
        end
        redirect_valid = 1'b1; redirect_target = 32'h20;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({fetch_valid, curr_pc, fetch_cnt} !== {1'b1, 32'h20, 32'd8}) begin
            errors++;
            $display("FAIL goto_20: valid=%b pc=%h cnt=%0d, expected 1/00000020/8", fetch_valid, curr_pc, fetch_cnt);
        end
    endtask

    task automatic test_halt_wrap();
        halt = 1'b1; fetch_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({fetch_valid, curr_pc, fetch_cnt} !== {1'b0, 32'h20, 32'd8}) begin
                errors++;
                $display("FAIL halt_hold[%0d]: valid=%b pc=%h cnt=%0d, expected 0/00000020/8",
                         i, fetch_valid, curr_pc, fetch_cnt);
            end
            redirect_valid = (i == 1);
            redirect_target = 32'h80;
        end
        redirect_valid = 1'b0;
        force dut.fetch_cnt = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.fetch_cnt;
        halt = 1'b0;
        @(negedge clk);
        checks++;
        if ({fetch_valid, curr_pc, fetch_cnt} !== {1'b1, 32'h20, 32'hFFFF_FFFE}) begin
            errors++;
            $display("FAIL halt_resume: valid=%b pc=%h cnt=%h, expected 1/00000020/fffffffe", fetch_valid, curr_pc, fetch_cnt);
        end
        @(negedge clk);
        checks++;
        if ({curr_pc, fetch_cnt} !== {32'h24, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL cnt_max: pc=%h cnt=%h, expected 00000024/ffffffff", curr_pc, fetch_cnt);
        end
        @(negedge clk);
        checks++;
        if ({curr_pc, fetch_cnt} !== {32'h28, 32'h0}) begin
            errors++;
            $display("FAIL cnt_wrap: pc=%h cnt=%h, expected 00000028/00000000", curr_pc, fetch_cnt);
        end
    endtask

    task automatic test_trap_in_halt();
        halt = 1'b1;
        @(negedge clk);
        checks++;
        if ({fetch_valid, curr_pc, fetch_cnt} !== {1'b0, 32'h28, 32'h0}) begin
            errors++;
            $display("FAIL halt_drops_fetch: valid=%b pc=%h cnt=%h, expected 0/00000028/00000000", fetch_valid, curr_pc, fetch_cnt);
        end
        trap_valid = 1'b1;
        @(negedge clk);
        checks++;
        if ({fetch_valid, curr_pc} !== {1'b0, 32'h100}) begin
            errors++;
            $display("FAIL halt_trap: valid=%b pc=%h, expected 0/00000100", fetch_valid, curr_pc);
        end
        trap_valid = 1'b0; halt = 1'b0;
        @(negedge clk);
        checks++;
        if ({fetch_valid, curr_pc} !== {1'b1, 32'h100}) begin
            errors++;
            $display("FAIL halt_trap_fetch: valid=%b pc=%h, expected 1/00000100", fetch_valid, curr_pc);
        end
    endtask

    task automatic test_pc_wrap();
        fetch_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({fetch_valid, curr_pc} !== {1'b1, 32'hFFFF_FFFC}) begin
            errors++;
            $display("FAIL pc_top: valid=%b pc=%h, expected 1/fffffffc", fetch_valid, curr_pc);
        end
        fetch_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({fetch_valid, curr_pc} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL pc_wrap: valid=%b pc=%h, expected 1/00000000", fetch_valid, curr_pc);
        end
    endtask

    task automatic test_reset_mid_bubble();
        fetch_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h43;
        @(negedge clk);
        checks++;
        if ({fetch_valid, misalign_err, bad_addr} !== {1'b0, 1'b1, 32'h43}) begin
            errors++;
            $display("FAIL pre_reset_bubble: valid=%b mis=%b bad=%h, expected 0/1/00000043", fetch_valid, misalign_err, bad_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fetch_valid, curr_pc, misalign_err, bad_addr, fetch_cnt} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL async_reset: valid=%b pc=%h mis=%b bad=%h cnt=%h, expected 0/0/0/0/0",
                     fetch_valid, curr_pc, misalign_err, bad_addr, fetch_cnt);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++;
        if ({fetch_valid, curr_pc} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reboot: valid=%b pc=%h, expected 0/00000000", fetch_valid, curr_pc);
        end
        @(negedge clk);
        checks++;
        if ({fetch_valid, curr_pc, fetch_cnt} !== {1'b1, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reboot_fetch: valid=%b pc=%h cnt=%h, expected 1/00000000/00000000", fetch_valid, curr_pc, fetch_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect();
        test_misalign();
        test_trap_redirect();
        test_bubble_redirect();
        test_halt_wrap();
        test_trap_in_halt();
        test_pc_wrap();
        test_reset_mid_bubble();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
